fifo_valid_ready_lvl: RTL and testbench

Parametrised valid/ready synchronous FIFO, next generation of the team's handshake FIFO. Adds:
- an occupancy count;
- programmable almost-full and almost-empty flags;
- a synchronous flush;
- an optional registered-output mode for timing closure.

It sits between any upstream and downstream valid/ready stages in the single-clock datapath.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem_2p.sv | 25 ++
 rtl/fifo_valid_ready_lvl.sv | 124 ++++++++++++
 tb/tb_fifo_valid_ready_lvl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Sizing helpers and elaboration-time parameter checks shared by the valid/ready FIFO family.
package fifo_pkg;

  localparam int unsigned MinDepth = 2;

  // Pointer width: index bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Level width: wide enough for DEPTH plus an output register entry.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

  function automatic bit params_ok(input int unsigned depth, input int unsigned out_reg,
                                   input int unsigned afull_th);
    int unsigned cap;
    cap = depth + ((out_reg != 0) ? 1 : 0);
    return (depth >= MinDepth) && ((depth & (depth - 1)) == 0) && (afull_th <= cap);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: synchronous write, asynchronous read, no reset.
module fifo_mem_2p #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fifo_valid_ready_lvl.sv
// Valid/ready synchronous FIFO with occupancy level, almost flags, flush and an
// optional registered output stage.
module fifo_valid_ready_lvl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned OUT_REG   = 0,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = ptr_w(DEPTH),
  localparam int unsigned LW = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW-1:0]    wr_ptr_display,
  output logic [AW-1:0]    rd_ptr_display
);

  localparam bit            ParamsOk  = params_ok(DEPTH, OUT_REG, AFULL_TH);
  localparam logic [LW-1:0] AfullTh   = LW'(AFULL_TH);
  localparam logic [LW-1:0] AemptyTh  = LW'(AEMPTY_TH);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] w_mem_rdata;
  logic             w_store_empty;
  logic             w_store_full;
  logic             w_push;
  logic             w_pop;
  logic             w_rd_adv;

  assign w_store_empty = (r_wr_ptr == r_rd_ptr);
  assign w_store_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                         (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop in the same cycle never opens the input when storage is full.
  assign up_ready = ~w_store_full & ~flush & ~rst;
  assign w_push   = up_valid & up_ready;
  assign w_pop    = down_valid & down_ready;

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_mem_rdata)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    // Refill the output stage whenever it is empty or draining this cycle.
    assign w_rd_adv   = ~w_store_empty & (~r_out_valid | w_pop);
    assign down_valid = r_out_valid & ~flush & ~rst;
    assign rd_data    = r_out_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_rd_adv) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mem_rdata;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end else begin : g_fwft
    assign w_rd_adv   = w_pop;
    assign down_valid = ~w_store_empty & ~flush & ~rst;
    assign rd_data    = w_mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign level          = r_level;
  assign almost_full    = (r_level >= AfullTh);
  assign almost_empty   = (r_level <= AemptyTh);
  assign wr_ptr_display = r_wr_ptr[AW-1:0];
  assign rd_ptr_display = r_rd_ptr[AW-1:0];

  always_ff @(posedge clk) begin : p_param_check
    assert (ParamsOk);
  end

endmodule

// File: tb/tb_fifo_valid_ready_lvl.sv
// Bench for fifo_valid_ready_lvl: a fall-through instance and a registered-output instance
// share stimulus and are each checked against a queue-based reference model.
module tb_fifo_valid_ready_lvl;

  localparam int D0 = 8;
  localparam int D1 = 4;
  localparam int Af0 = D0 - 2;
  localparam int Ae0 = 2;
  localparam int Af1 = 4;
  localparam int Ae1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       up_valid;
  logic       down_ready;
  logic [7:0] wr_data;

  logic       ur0, dv0, af0, ae0;
  logic [7:0] rd0;
  logic [3:0] lv0;
  logic [2:0] wp0, rp0;

  logic       ur1, dv1, af1, ae1;
  logic [7:0] rd1;
  logic [2:0] lv1;
  logic [1:0] wp1, rp1;

  always #5 clk = ~clk;

  fifo_valid_ready_lvl #(
    .WIDTH(8), .DEPTH(D0), .OUT_REG(0), .AFULL_TH(Af0), .AEMPTY_TH(Ae0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(ur0),
    .wr_data(wr_data), .down_valid(dv0), .down_ready(down_ready), .rd_data(rd0),
    .level(lv0), .almost_full(af0), .almost_empty(ae0),
    .wr_ptr_display(wp0), .rd_ptr_display(rp0)
  );

  fifo_valid_ready_lvl #(
    .WIDTH(8), .DEPTH(D1), .OUT_REG(1), .AFULL_TH(Af1), .AEMPTY_TH(Ae1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(ur1),
    .wr_data(wr_data), .down_valid(dv1), .down_ready(down_ready), .rd_data(rd1),
    .level(lv1), .almost_full(af1), .almost_empty(ae1),
    .wr_ptr_display(wp1), .rd_ptr_display(rp1)
  );

  // Reference model: mode 0 is one queue; mode 1 is a storage queue plus an output slot.
  logic [7:0] q0[$];
  int         wc0, rc0;
  logic [7:0] s1[$];
  bit         ov1;
  logic [7:0] od1;
  int         wc1, rc1;

  int n_chk;
  int n_fail;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit f, input bit uv, input logic [7:0] d,
                       input bit dr);
    bit exp_ur0, exp_dv0, exp_ur1, exp_dv1, ld1;
    int lvl0, lvl1;
    @(negedge clk);
    rst = r; flush = f; up_valid = uv; wr_data = d; down_ready = dr;
    #1;
    lvl0    = q0.size();
    lvl1    = s1.size() + (ov1 ? 1 : 0);
    exp_ur0 = !r && !f && (q0.size() < D0);
    exp_dv0 = !r && !f && (q0.size() > 0);
    exp_ur1 = !r && !f && (s1.size() < D1);
    exp_dv1 = !r && !f && ov1;

    check_val("ur0", 32'(ur0), 32'(exp_ur0));
    check_val("dv0", 32'(dv0), 32'(exp_dv0));
    check_val("lvl0", 32'(lv0), 32'(lvl0));
    check_val("af0", 32'(af0), 32'(lvl0 >= Af0));
    check_val("ae0", 32'(ae0), 32'(lvl0 <= Ae0));
    check_val("wp0", 32'(wp0), 32'(wc0 % D0));
    check_val("rp0", 32'(rp0), 32'(rc0 % D0));
    if (exp_dv0) check_val("rd0", 32'(rd0), 32'(q0[0]));

    check_val("ur1", 32'(ur1), 32'(exp_ur1));
    check_val("dv1", 32'(dv1), 32'(exp_dv1));
    check_val("lvl1", 32'(lv1), 32'(lvl1));
    check_val("af1", 32'(af1), 32'(lvl1 >= Af1));
    check_val("ae1", 32'(ae1), 32'(lvl1 <= Ae1));
    check_val("wp1", 32'(wp1), 32'(wc1 % D1));
    check_val("rp1", 32'(rp1), 32'(rc1 % D1));
    if (exp_dv1) check_val("rd1", 32'(rd1), 32'(od1));

    @(posedge clk);
    if (r || f) begin
      q0.delete(); wc0 = 0; rc0 = 0;
    end else begin
      if (exp_dv0 && dr) begin void'(q0.pop_front()); rc0++; end
      if (exp_ur0 && uv) begin q0.push_back(d); wc0++; end
    end

    if (r || f) begin
      s1.delete(); ov1 = 1'b0; wc1 = 0; rc1 = 0;
      if (r) od1 = 8'h00;
    end else begin
      ld1 = (s1.size() > 0) && (!ov1 || (exp_dv1 && dr));
      if (exp_dv1 && dr) ov1 = 1'b0;
      if (ld1) begin od1 = s1.pop_front(); ov1 = 1'b1; rc1++; end
      if (exp_ur1 && uv) begin s1.push_back(d); wc1++; end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    wc0 = 0; rc0 = 0; wc1 = 0; rc1 = 0; ov1 = 1'b0; od1 = 8'h00;
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; wr_data = 8'h00; down_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with traffic offered: nothing may complete.
    cycle(1, 0, 1, 8'hFF, 1);
    #2;
    check_val("rst_ur0", 32'(ur0), 32'd0);
    check_val("rst_ae0", 32'(ae0), 32'd1);
    check_val("rst_af0", 32'(af0), 32'd0);
    check_val("rst_rd1", 32'(rd1), 32'h00);

    // Fill from empty with the consumer stalled.
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, 8'(i), 0);
    #2;
    check_val("fill_lvl0", 32'(lv0), 32'd8);
    check_val("fill_ur0", 32'(ur0), 32'd0);
    check_val("fill_wp0", 32'(wp0), 32'd0);
    check_val("fill_af0", 32'(af0), 32'd1);
    check_val("fill_lvl1", 32'(lv1), 32'd5);

    // Drain everything.
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 8'h00, 1);
    #2;
    check_val("drain_lvl0", 32'(lv0), 32'd0);
    check_val("drain_dv0", 32'(dv0), 32'd0);

    // Hold level 4 with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 8'($urandom), 1);
    #2;
    check_val("steady_lvl0", 32'(lv0), 32'd4);

    // Full with both sides willing: pop only, then the push lands.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'($urandom), 0);
    cycle(0, 0, 1, 8'h5A, 1);
    #2;
    check_val("full_pop_lvl0", 32'(lv0), 32'd7);
    cycle(0, 0, 1, 8'h5B, 0);
    #2;
    check_val("full_push_lvl0", 32'(lv0), 32'd8);

    // Flush at level 5 while both sides are willing.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 1, 1, 8'h77, 1);
    #2;
    check_val("flush_lvl0", 32'(lv0), 32'd0);
    check_val("flush_dv0", 32'(dv0), 32'd0);
    cycle(0, 0, 0, 8'h00, 0);
    #2;
    check_val("flush_ur0", 32'(ur0), 32'd1);

    // Registered output: two-cycle latency, capacity DEPTH+1.
    cycle(0, 0, 1, 8'hA5, 0);
    #2;
    check_val("oreg_dv_n", 32'(dv1), 32'd0);
    cycle(0, 0, 0, 8'h00, 0);
    #2;
    check_val("oreg_dv_n1", 32'(dv1), 32'd1);
    check_val("oreg_rd", 32'(rd1), 32'hA5);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 8'($urandom), 0);
    #2;
    check_val("oreg_cap_lvl1", 32'(lv1), 32'd5);
    check_val("oreg_cap_ur1", 32'(ur1), 32'd0);

    // Random traffic: producer-heavy then consumer-heavy, with sporadic flush and reset.
    for (int i = 0; i < 600; i++) begin
      bit hp;
      hp = (i < 300);
      cycle($urandom_range(63) == 0, $urandom_range(24) == 0,
            hp ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0),
            8'($urandom),
            hp ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
